soc_fabric: RTL and testbench
=============================

SOC_FABRIC -- requirements
Module: soc_fabric

Interface
REQ-001 SHALL have parameter AW, 32, address width.
REQ-002 SHALL have parameter DW, 32, data width; multiple of 8.
REQ-003 SHALL have parameter NSLV, 4, number of slave ports; 2..16.
REQ-004 SHALL have parameter SEL_LSB, 28, LSB of the slave-index field m_addr[SEL_LSB +: clog2(NSLV)].
REQ-005 SHALL have parameter TO_CYC, 255, timeout limit in cycles; 1..65535.
REQ-006 SHALL have parameter ERR_DATA, 'hDEAD_BEEF truncated to DW, rdat returned on error.
REQ-007 SHALL have port clk  in  1  bus clock; single clock domain.
REQ-008 SHALL have port arst_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port m_vld  in  1  master request.
REQ-010 SHALL have port m_rdy  out  1  master acknowledge.
REQ-011 SHALL have port m_addr  in  AW  address.
REQ-012 SHALL have port m_we  in  DW/8  byte write enables; all-zero means read.
REQ-013 SHALL have port m_wdat  in  DW  write data.
REQ-014 SHALL have port m_rdat  out  DW  read data.
REQ-015 SHALL have port m_err  out  1  error flag, qualified by m_vld&m_rdy.
REQ-016 SHALL have port s_vld  out  NSLV  per-slave request.
REQ-017 SHALL have port s_rdy  in  NSLV  per-slave acknowledge.
REQ-018 SHALL have ports s_addr/s_we/s_wdat  out  AW/DW/8/DW  broadcast copies of m_addr/m_we/m_wdat.
REQ-019 SHALL have port s_rdat  in  NSLV*DW  per-slave read data, slave i in bits [i*DW +: DW].

Function
REQ-020 SHALL decode idx = m_addr[SEL_LSB +: clog2(NSLV)]; idx >= NSLV is unmapped.
REQ-021 SHALL implement FSM IDLE, WAIT, ERR; a transfer completes when m_vld&m_rdy.
REQ-022 SHALL, for a mapped idx in IDLE/WAIT, drive s_vld[idx]=m_vld, all other s_vld=0, m_rdy=s_rdy[idx], m_rdat=s_rdat[idx], m_err=0; zero added latency.
REQ-023 SHALL move IDLE->WAIT when m_vld & mapped & ~s_rdy[idx]; WAIT->IDLE on s_rdy[idx].
REQ-024 SHALL, on m_vld with an unmapped idx in IDLE, assert no s_vld, enter ERR next cycle, then give m_rdy=1, m_err=1, m_rdat=ERR_DATA for exactly one cycle and return to IDLE.
REQ-025 SHALL treat back-to-back transfers (m_vld held after a completion) as new requests with no idle cycle.
REQ-026 SHALL leave m_rdat=0 while no completion is signalled.
REQ-027 SHALL ignore s_rdy of non-selected slaves.
REQ-028 SHALL not sample master signals for changes in WAIT; the master holds them stable until m_rdy.

Reset
REQ-029 SHALL, while arst_n=0, force state IDLE, timeout counter 0, m_rdy=0, m_err=0, m_rdat=0, s_vld=0.
REQ-030 SHALL, on reset assertion mid-transfer, abort the transfer with no completion; the first cycle after release is IDLE.

Configuration
REQ-031 SHALL, with SOC_FABRIC_TIMEOUT_EN defined, count cycles in WAIT (16-bit, saturating, cleared on leaving WAIT).
REQ-032 SHALL, when the count reaches TO_CYC, drop s_vld and go to ERR, completing with m_err=1 and m_rdat=ERR_DATA.
REQ-033 SHALL give priority to a real s_rdy over timeout when both occur in the same cycle.
REQ-034 SHALL, without SOC_FABRIC_TIMEOUT_EN, omit counter logic; WAIT persists until s_rdy; m_err comes only from decode.

Structure
REQ-035 SHALL keep the state enum, ERR_DATA default and clog2 helper in soc_pkg.
REQ-036 SHALL place the timeout counter in sub-module soc_fabric_tmr, instantiated only under SOC_FABRIC_TIMEOUT_EN.

Verification
REQ-037 SHALL cover: write addr 0x1000_0004, we=F, slave1 s_rdy=1 -> s_vld=0010, completion in the same cycle, m_err=0.
REQ-038 SHALL cover: read addr 0x2000_0000, slave2 waits 3 cycles then returns 0x1234_5678 -> m_rdy on cycle 4 with m_rdat=0x1234_5678.
REQ-039 SHALL cover: NSLV=3, addr 0x3000_0000 -> no s_vld, m_rdy/m_err=1 one cycle later, m_rdat=0xDEAD_BEEF.
REQ-040 SHALL cover, with TIMEOUT_EN and TO_CYC=8: slave never ready -> s_vld dropped after 8 WAIT cycles, then one error completion; s_rdy arriving on cycle 8 -> normal completion.
REQ-041 SHALL cover: arst_n pulsed low during WAIT -> all outputs 0, IDLE after release, next read completes normally.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared types and helpers for the SoC request fabric.
// Holds the FSM state encoding, the default error read-data word and a
// constant-evaluable ceil(log2) used to size the slave-index field.
package soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
    localparam int          TMR_W        = 16;

    // Smallest r with 2**r >= n (n >= 2 in this fabric).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/soc_fabric_tmr.sv
// Wait-state watchdog for soc_fabric: counts cycles spent in WAIT with a
// 16-bit saturating counter and flags expiry on the TO_CYC-th WAIT cycle.
// Only instantiated when SOC_FABRIC_TIMEOUT_EN is defined.
module soc_fabric_tmr
    import soc_pkg::*;
#(
    parameter int TO_CYC = 255
) (
    input  logic clk,
    input  logic arst_n,
    input  logic in_wait_i,   // FSM currently in WAIT
    input  logic stay_i,      // FSM remains in WAIT next cycle
    output logic expire_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;
    logic [TMR_W:0]   cnt_inc_s;

    assign cnt_inc_s = {1'b0, cnt_q} + {{TMR_W{1'b0}}, 1'b1};

    // The current WAIT cycle is number cnt_q+1; expire when that hits the limit.
    assign expire_o = in_wait_i && (cnt_inc_s >= (TMR_W + 1)'(TO_CYC));

    // Next count: saturating increment while staying in WAIT, else cleared.
    always_comb begin
        cnt_d = {TMR_W{1'b0}};
        if (in_wait_i && stay_i) begin
            if (cnt_q == {TMR_W{1'b1}}) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_inc_s[TMR_W-1:0];
            end
        end else begin
            cnt_d = {TMR_W{1'b0}};
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= {TMR_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/soc_fabric.sv
// Single-master to NSLV-slave request fabric with address decode.
// Mapped requests pass straight through to the selected slave with no added
// latency; unmapped requests complete one cycle later with m_err and
// ERR_DATA. Optional wait-state timeout: define SOC_FABRIC_TIMEOUT_EN.
module soc_fabric
    import soc_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            NSLV     = 4,
    parameter int            SEL_LSB  = 28,
    parameter int            TO_CYC   = 255,
    parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               m_vld,
    output logic               m_rdy,
    input  logic [AW-1:0]      m_addr,
    input  logic [DW/8-1:0]    m_we,
    input  logic [DW-1:0]      m_wdat,
    output logic [DW-1:0]      m_rdat,
    output logic               m_err,
    output logic [NSLV-1:0]    s_vld,
    input  logic [NSLV-1:0]    s_rdy,
    output logic [AW-1:0]      s_addr,
    output logic [DW/8-1:0]    s_we,
    output logic [DW-1:0]      s_wdat,
    input  logic [NSLV*DW-1:0] s_rdat
);

    localparam int IW = clog2(NSLV);

    state_e          state_q;
    state_e          state_d;
    logic [IW-1:0]   idx_s;
    logic            mapped_s;
    logic            sel_rdy_s;
    logic [DW-1:0]   sel_rdat_s;
    logic            expire_s;
    logic            m_rdy_s;
    logic            m_err_s;
    logic [DW-1:0]   m_rdat_s;
    logic [NSLV-1:0] s_vld_s;

    assign idx_s    = m_addr[SEL_LSB +: IW];
    assign mapped_s = (32'(idx_s) < 32'(NSLV));

    // Broadcast request payload to every slave.
    assign s_addr = m_addr;
    assign s_we   = m_we;
    assign s_wdat = m_wdat;

    // Pick ready/read-data of the addressed slave; others are ignored.
    always_comb begin
        logic hit;
        sel_rdy_s  = 1'b0;
        sel_rdat_s = {DW{1'b0}};
        hit        = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            hit        = (idx_s == IW'(i));
            sel_rdy_s  = sel_rdy_s | (s_rdy[i] & hit);
            sel_rdat_s = sel_rdat_s | (s_rdat[i*DW +: DW] & {DW{hit}});
        end
    end

`ifdef SOC_FABRIC_TIMEOUT_EN
    soc_fabric_tmr #(
        .TO_CYC (TO_CYC)
    ) u_tmr (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_wait_i (state_q == ST_WAIT),
        .stay_i    (state_d == ST_WAIT),
        .expire_o  (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // Next-state decode; a real slave ready wins over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m_vld && !mapped_s) begin
                    state_d = ST_ERR;
                end else if (m_vld && !sel_rdy_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (sel_rdy_s) begin
                    state_d = ST_IDLE;
                end else if (expire_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Master/slave handshake outputs; read data is zero unless completing.
    always_comb begin
        m_rdy_s  = 1'b0;
        m_err_s  = 1'b0;
        m_rdat_s = {DW{1'b0}};
        s_vld_s  = {NSLV{1'b0}};
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (mapped_s) begin
                    s_vld_s  = {{(NSLV-1){1'b0}}, m_vld} << idx_s;
                    m_rdy_s  = sel_rdy_s;
                    m_rdat_s = (m_vld && sel_rdy_s) ? sel_rdat_s : {DW{1'b0}};
                end else begin
                    s_vld_s  = {NSLV{1'b0}};
                    m_rdy_s  = 1'b0;
                end
            end
            ST_ERR: begin
                m_rdy_s  = 1'b1;
                m_err_s  = 1'b1;
                m_rdat_s = ERR_DATA;
            end
            default: begin
                m_rdy_s  = 1'b0;
            end
        endcase
    end

    // Hold every handshake output low for as long as reset is asserted.
    assign m_rdy  = arst_n & m_rdy_s;
    assign m_err  = arst_n & m_err_s;
    assign m_rdat = m_rdat_s & {DW{arst_n}};
    assign s_vld  = s_vld_s & {NSLV{arst_n}};

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_soc_fabric.sv
// Directed scoreboard bench for soc_fabric (NSLV=3, TO_CYC=8).
module tb_soc_fabric;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              m_vld;
    logic              m_rdy;
    logic [AW-1:0]     m_addr;
    logic [DW/8-1:0]   m_we;
    logic [DW-1:0]     m_wdat;
    logic [DW-1:0]     m_rdat;
    logic              m_err;
    logic [NS-1:0]     s_vld;
    logic [NS-1:0]     s_rdy;
    logic [AW-1:0]     s_addr;
    logic [DW/8-1:0]   s_we;
    logic [DW-1:0]     s_wdat;
    logic [NS*DW-1:0]  s_rdat;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [DW-1:0] rdat;
        logic          err;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    soc_fabric #(
        .AW      (AW),
        .DW      (DW),
        .NSLV    (NS),
        .SEL_LSB (28),
        .TO_CYC  (8)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .m_vld  (m_vld),
        .m_rdy  (m_rdy),
        .m_addr (m_addr),
        .m_we   (m_we),
        .m_wdat (m_wdat),
        .m_rdat (m_rdat),
        .m_err  (m_err),
        .s_vld  (s_vld),
        .s_rdy  (s_rdy),
        .s_addr (s_addr),
        .s_we   (s_we),
        .s_wdat (s_wdat),
        .s_rdat (s_rdat)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.rdat = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_slv(input int i, input logic [DW-1:0] d);
        s_rdat[i*DW +: DW] = d;
    endtask

    // Monitor: every completion seen on the master port is scored in order.
    always @(negedge clk) begin
        if (arst_n === 1'b1 && m_vld && m_rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_completion: rdat 0x%0h err %0b, expected none at %0t",
                         m_rdat, m_err, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cpl_rdat", 64'(m_rdat), 64'(e.rdat));
                chk("cpl_err",  64'(m_err),  64'(e.err));
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset with busy-looking inputs: outputs must still be all zero.
        arst_n = 1'b0;
        m_vld  = 1'b1;
        m_addr = 32'h1000_0000;
        m_we   = 4'h0;
        m_wdat = 32'h0;
        s_rdy  = {NS{1'b1}};
        s_rdat = {(NS*DW){1'b1}};
        @(negedge clk);
        chk("rst_m_rdy",  64'(m_rdy),  64'd0);
        chk("rst_m_err",  64'(m_err),  64'd0);
        chk("rst_m_rdat", 64'(m_rdat), 64'd0);
        chk("rst_s_vld",  64'(s_vld),  64'd0);
        step();
        m_vld  = 1'b0;
        s_rdy  = {NS{1'b0}};
        s_rdat = {(NS*DW){1'b0}};
        arst_n = 1'b1;
        step();

        // Write to slave1, ready immediately: same-cycle completion.
        m_vld  = 1'b1;
        m_addr = 32'h1000_0004;
        m_we   = 4'hF;
        m_wdat = 32'hA5A5_0001;
        s_rdy  = 3'b010;
        push(32'h0, 1'b0);
        @(negedge clk);
        chk("wr_s_vld",  64'(s_vld),  64'h2);
        chk("wr_m_rdy",  64'(m_rdy),  64'd1);
        chk("wr_s_addr", 64'(s_addr), 64'h1000_0004);
        chk("wr_s_we",   64'(s_we),   64'hF);
        chk("wr_s_wdat", 64'(s_wdat), 64'hA5A5_0001);
        step();
        m_vld = 1'b0;
        s_rdy = 3'b000;
        m_we  = 4'h0;
        step();

        // Read from slave2 waiting 3 cycles; other slaves ready but ignored.
        m_vld  = 1'b1;
        m_addr = 32'h2000_0000;
        set_slv(0, 32'hAAAA_0000);
        set_slv(1, 32'hBBBB_0001);
        set_slv(2, 32'h1234_5678);
        s_rdy  = 3'b011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rdw_m_rdy",  64'(m_rdy),  64'd0);
            chk("rdw_m_rdat", 64'(m_rdat), 64'd0);
            chk("rdw_s_vld",  64'(s_vld),  64'h4);
            step();
        end
        s_rdy = 3'b100;
        push(32'h1234_5678, 1'b0);
        @(negedge clk);
        chk("rdw_cpl_rdy", 64'(m_rdy), 64'd1);
        step();

        // Back-to-back reads: slave0 then slave1 with no idle cycle.
        m_addr = 32'h0000_0010;
        s_rdy  = 3'b001;
        push(32'hAAAA_0000, 1'b0);
        @(negedge clk);
        chk("b2b0_s_vld", 64'(s_vld), 64'h1);
        step();
        m_addr = 32'h1000_0020;
        s_rdy  = 3'b010;
        push(32'hBBBB_0001, 1'b0);
        @(negedge clk);
        chk("b2b1_s_vld", 64'(s_vld), 64'h2);
        step();
        m_vld = 1'b0;
        s_rdy = 3'b000;
        step();

        // Unmapped index 3: no slave request, error completion a cycle later.
        m_vld  = 1'b1;
        m_addr = 32'h3000_0000;
        s_rdy  = 3'b111;
        @(negedge clk);
        chk("um_s_vld0",  64'(s_vld),  64'd0);
        chk("um_m_rdy0",  64'(m_rdy),  64'd0);
        chk("um_m_rdat0", 64'(m_rdat), 64'd0);
        step();
        push(32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        chk("um_s_vld1", 64'(s_vld), 64'd0);
        chk("um_m_rdy1", 64'(m_rdy), 64'd1);
        step();
        m_vld = 1'b0;
        s_rdy = 3'b000;
        @(negedge clk);
        chk("um_after_rdy", 64'(m_rdy), 64'd0);
        chk("um_after_err", 64'(m_err), 64'd0);
        step();

`ifdef SOC_FABRIC_TIMEOUT_EN
        // Slave0 never ready: 8 WAIT cycles then error completion.
        m_vld  = 1'b1;
        m_addr = 32'h0000_0000;
        @(negedge clk);
        chk("to_idle_s_vld", 64'(s_vld), 64'h1);
        step();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("to_wait_s_vld", 64'(s_vld), 64'h1);
            chk("to_wait_m_rdy", 64'(m_rdy), 64'd0);
            step();
        end
        push(32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        chk("to_err_s_vld", 64'(s_vld), 64'd0);
        chk("to_err_m_rdy", 64'(m_rdy), 64'd1);
        step();
        m_vld = 1'b0;
        step();

        // Ready on WAIT cycle 8 beats the timeout: normal completion.
        m_vld = 1'b1;
        set_slv(0, 32'h0BAD_CAFE);
        step();
        for (int c = 0; c < 7; c++) begin
            step();
        end
        s_rdy = 3'b001;
        push(32'h0BAD_CAFE, 1'b0);
        @(negedge clk);
        chk("to_race_m_rdy", 64'(m_rdy), 64'd1);
        step();
        m_vld = 1'b0;
        s_rdy = 3'b000;
        @(negedge clk);
        chk("to_race_no_err", 64'(m_err), 64'd0);
        chk("to_race_no_rdy", 64'(m_rdy), 64'd0);
        step();
`else
        // No timeout: WAIT persists for many cycles until the slave answers.
        m_vld  = 1'b1;
        m_addr = 32'h0000_0000;
        set_slv(0, 32'h0BAD_CAFE);
        for (int c = 0; c < 20; c++) begin
            step();
        end
        @(negedge clk);
        chk("nto_s_vld", 64'(s_vld), 64'h1);
        chk("nto_m_rdy", 64'(m_rdy), 64'd0);
        step();
        s_rdy = 3'b001;
        push(32'h0BAD_CAFE, 1'b0);
        @(negedge clk);
        chk("nto_cpl_rdy", 64'(m_rdy), 64'd1);
        step();
        m_vld = 1'b0;
        s_rdy = 3'b000;
        step();
`endif

        // Reset pulsed during WAIT aborts the transfer.
        m_vld  = 1'b1;
        m_addr = 32'h2000_0000;
        step();
        step();
        arst_n = 1'b0;
        s_rdy  = 3'b111;
        @(negedge clk);
        chk("rw_m_rdy",  64'(m_rdy),  64'd0);
        chk("rw_m_err",  64'(m_err),  64'd0);
        chk("rw_m_rdat", 64'(m_rdat), 64'd0);
        chk("rw_s_vld",  64'(s_vld),  64'd0);
        step();
        m_vld  = 1'b0;
        s_rdy  = 3'b000;
        arst_n = 1'b1;
        @(negedge clk);
        chk("rw_rel_m_rdy", 64'(m_rdy), 64'd0);
        chk("rw_rel_s_vld", 64'(s_vld), 64'd0);
        step();
        // FSM must be in IDLE: an unmapped request errors one cycle later.
        m_vld  = 1'b1;
        m_addr = 32'h3000_0000;
        step();
        push(32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        chk("rw_idle_err", 64'(m_err), 64'd1);
        step();
        m_vld = 1'b0;
        step();
        // Next read completes normally.
        m_vld  = 1'b1;
        m_addr = 32'h1000_0000;
        set_slv(1, 32'hC0DE_0042);
        s_rdy  = 3'b010;
        push(32'hC0DE_0042, 1'b0);
        @(negedge clk);
        chk("rw_rd_m_rdy", 64'(m_rdy), 64'd1);
        step();
        m_vld = 1'b0;
        s_rdy = 3'b000;
        step();
        step();

        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_completions: %0d outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
